// File: rtl/fulladder_cell.sv
// Full-adder cell: {cout,sum} = a + b + cin with carry-lookahead helpers.
// REG_OUT=1 registers results behind in_valid; REG_OUT=0 is purely combinational.
module fulladder_cell #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             gen,
  output logic             prop,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0] full;
  logic           carry_msb;
  logic           prop_c;
  logic           gen_c;
  logic           ovf_c;

  assign full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign prop_c = &(a ^ b);
  // When every bit propagates, a+b is all-ones and cannot carry, so any
  // carry-out must have come from cin; otherwise cout equals generate.
  assign gen_c  = full[WIDTH] & ~(prop_c & cin);
  // Recover the carry into the MSB from the MSB sum bit.
  assign carry_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ full[WIDTH-1];
  assign ovf_c     = carry_msb ^ full[WIDTH];

  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        sum       <= '0;
        cout      <= 1'b0;
        gen       <= 1'b0;
        prop      <= 1'b0;
        ovf       <= 1'b0;
        out_valid <= 1'b0;
      end else if (in_valid) begin
        sum       <= full[WIDTH-1:0];
        cout      <= full[WIDTH];
        gen       <= gen_c;
        prop      <= prop_c;
        ovf       <= ovf_c;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = clk;
    assign sum        = full[WIDTH-1:0];
    assign cout       = full[WIDTH];
    assign gen        = gen_c;
    assign prop       = prop_c;
    assign ovf        = ovf_c;
    assign out_valid  = in_valid & ~rst;
  end

endmodule

// File: tb/tb_fulladder_cell.sv
// Self-checking bench: 1-bit registered slice, 4-slice combinational ripple
// chain and 4-bit registered adder, checked against integer arithmetic.
module tb_fulladder_cell;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 1-bit registered slice
  logic v1, a1, b1, c1;
  logic s1, co1, g1, p1, o1, ov1;
  fulladder_cell #(.WIDTH(1), .REG_OUT(1'b1)) u_bit (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1), .gen(g1), .prop(p1), .ovf(o1), .out_valid(ov1)
  );

  // Four combinational slices rippled
  logic       rv;
  logic [3:0] ra, rb;
  logic [4:0] rc;
  logic [3:0] rs, rg, rp, ro, rov;
  for (genvar i = 0; i < 4; i++) begin : g_rip
    fulladder_cell #(.WIDTH(1), .REG_OUT(1'b0)) u_slice (
      .clk(clk), .rst(rst), .in_valid(rv), .a(ra[i]), .b(rb[i]), .cin(rc[i]),
      .sum(rs[i]), .cout(rc[i+1]), .gen(rg[i]), .prop(rp[i]), .ovf(ro[i]),
      .out_valid(rov[i])
    );
  end

  // 4-bit registered adder
  logic       v4, c4;
  logic [3:0] a4, b4, s4;
  logic       co4, g4, p4, o4, ov4;
  fulladder_cell #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .sum(s4), .cout(co4), .gen(g4), .prop(p4), .ovf(o4), .out_valid(ov4)
  );

  // Reference for the 4-bit adder, from integer arithmetic
  function automatic logic [8:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int t, sa, sb, sr;
    logic [3:0] s;
    logic co, g, p, o, v;
    t  = int'(a) + int'(b) + int'(c);
    s  = t[3:0];
    co = (t >= 16);
    g  = (int'(a) + int'(b)) >= 16;
    p  = ((a ^ b) == 4'hF);
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    sr = sa + sb + int'(c);
    o  = (sr > 7) || (sr < -8);
    v  = 1'b1;
    return {v, o, p, g, co, s};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s1, co1, g1, p1, o1, ov1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_bit: got %b expected 000000", {s1, co1, g1, p1, o1, ov1});
    end
    checks++;
    if ({s4, co4, g4, p4, o4, ov4} !== 9'b0) begin
      errors++;
      $display("FAIL reset_w4: got %b expected 000000000", {s4, co4, g4, p4, o4, ov4});
    end
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0; v4 = 1'b0;
  endtask

  task automatic test_exhaustive();
    logic [7:0] sum_tab;
    logic [7:0] cout_tab;
    sum_tab  = 8'b1001_0110;
    cout_tab = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v1 = 1'b1; a1 = i[2]; b1 = i[1]; c1 = i[0];
      @(posedge clk); #1;
      checks++;
      if ({s1, co1, ov1} !== {sum_tab[i], cout_tab[i], 1'b1}) begin
        errors++;
        $display("FAIL exhaustive abc=%0d: got sum,cout,valid=%b expected %b",
                 i, {s1, co1, ov1}, {sum_tab[i], cout_tab[i], 1'b1});
      end
      checks++;
      if (co1 !== (g1 | (p1 & c1)) || o1 !== (c1 ^ co1)) begin
        errors++;
        $display("FAIL lookahead_bit abc=%0d: got g,p,ovf=%b%b%b cout=%b", i, g1, p1, o1, co1);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s1, co1, ov1} !== 3'b010) begin
      errors++;
      $display("FAIL hold: got sum,cout,valid=%b expected 010", {s1, co1, ov1});
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s1, co1, g1, p1, o1, ov1} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 000000", {s1, co1, g1, p1, o1, ov1});
    end
    @(negedge clk);
    rst = 1'b0; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s1, co1, ov1} !== 3'b101) begin
      errors++;
      $display("FAIL post_reset: got sum,cout,valid=%b expected 101", {s1, co1, ov1});
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic check_ripple(input string name, input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] exp;
    ra = a; rb = b; rc[0] = c; rv = 1'b1;
    #1;
    exp = 5'(int'(a) + int'(b) + int'(c));
    checks++;
    if ({rc[4], rs} !== exp) begin
      errors++;
      $display("FAIL %s a=%h b=%h cin=%b: got %h expected %h", name, a, b, c, {rc[4], rs}, exp);
    end
  endtask

  task automatic test_ripple();
    check_ripple("ripple_wrap", 4'hF, 4'h1, 1'b0);
    check_ripple("ripple_5p3c", 4'h5, 4'h3, 1'b1);
    check_ripple("ripple_allones", 4'hF, 4'hF, 1'b1);
    for (int s = 0; s < 64; s++)
      check_ripple("ripple_sweep", 4'(s / 4), 4'(s / 2), 1'(s));
    rv = 1'b1; rst = 1'b1; #1;
    checks++;
    if (rov !== 4'b0000) begin
      errors++;
      $display("FAIL ripple_valid_rst: got %b expected 0000", rov);
    end
    rst = 1'b0; rv = 1'b0; #1;
    checks++;
    if (rov !== 4'b0000) begin
      errors++;
      $display("FAIL ripple_valid_idle: got %b expected 0000", rov);
    end
    rv = 1'b1; #1;
    checks++;
    if (rov !== 4'b1111) begin
      errors++;
      $display("FAIL ripple_valid_on: got %b expected 1111", rov);
    end
  endtask

  task automatic drive_w4(input string name, input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [8:0] exp;
    @(negedge clk);
    v4 = 1'b1; a4 = a; b4 = b; c4 = c;
    exp = ref4(a, b, c);
    @(posedge clk); #1;
    checks++;
    if ({ov4, o4, p4, g4, co4, s4} !== exp) begin
      errors++;
      $display("FAIL %s a=%h b=%h cin=%b: got valid,ovf,prop,gen,cout,sum=%b expected %b",
               name, a, b, c, {ov4, o4, p4, g4, co4, s4}, exp);
    end
  endtask

  task automatic test_width4();
    drive_w4("w4_ovf", 4'b0111, 4'b0001, 1'b0);
    drive_w4("w4_prop", 4'b1010, 4'b0101, 1'b1);
    drive_w4("w4_wrap", 4'hF, 4'hF, 1'b1);
    drive_w4("w4_zero", 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      drive_w4("w4_random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom));
    @(negedge clk);
    v4 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("FAIL w4_valid_drop: got %b expected 0", ov4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    rv = 1'b0; ra = '0; rb = '0; rc[0] = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_exhaustive();
    test_hold();
    test_mid_reset();
    test_ripple();
    test_width4();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fulladder_cell.md
Name: fulladder_cell

Overview:
Registered binary full-adder cell computing {cout,sum} = a + b + cin, with a valid qualifier and carry-lookahead helper outputs. At WIDTH=1 it is the bit slice chained into ripple-carry adders: cout of slice i feeds cin of slice i+1. Wider WIDTH gives a single-stage multi-bit adder. REG_OUT selects registered (1-cycle) or combinational outputs, so chained slices can ripple within one cycle.

Parameters:
WIDTH, 1, operand/sum width in bits (>=1)
REG_OUT, 1, 1 = outputs registered on clk (latency 1); 0 = outputs combinational (latency 0)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands valid this cycle
a  input  WIDTH  operand A (unsigned; two's complement for ovf)
b  input  WIDTH  operand B
cin  input  1  carry in
sum  output  WIDTH  (a+b+cin) mod 2^WIDTH
cout  output  1  carry out of MSB
gen  output  1  group generate: carry out of a+b with cin=0
prop  output  1  group propagate: &(a^b)
ovf  output  1  signed overflow: carry into MSB XOR cout
out_valid  output  1  sum/cout/gen/prop/ovf valid

Behaviour:
- Arithmetic: {cout,sum} = a + b + cin, computed WIDTH+1 bits wide, no truncation of carry. WIDTH=1: sum = a^b^cin, cout = (a&b)|(cin&(a^b)).
- gen/prop defined over whole WIDTH-bit group; identity cout = gen | (prop & cin) must always hold.
- ovf: carry into bit WIDTH-1 XOR cout; for WIDTH=1 equals cin XOR cout.
- REG_OUT=1:
  - On rising clk with rst=1: sum, cout, gen, prop, ovf, out_valid all <= 0. rst overrides in_valid.
  - rst=0, in_valid=1: all result outputs load values computed from a, b, cin; out_valid <= 1. Latency exactly 1 cycle; one result accepted per cycle, no stall.
  - rst=0, in_valid=0: result outputs hold previous values; out_valid <= 0.
  - Reset asserted mid-stream: results in flight are discarded; first valid result after reset release appears the cycle after the first in_valid=1 sampled with rst=0.
- REG_OUT=0:
  - All result outputs purely combinational from a, b, cin; out_valid = in_valid & ~rst. clk unused.
  - sum/cout track inputs regardless of in_valid and rst.
  - No internal state; no combinational loop when cout is chained to the next slice's cin.
- Inputs are never X-checked; any 0/1 input combination is legal, including all-ones operands with cin=1 (wrap-around: sum = all-ones, cout=1).

Test Plan:
- WIDTH=1, REG_OUT=1, exhaustive 8 combos of a,b,cin with in_valid=1 -> next cycle (sum,cout) = (0,0),(1,0),(1,0),(0,1),(1,0),(0,1),(0,1),(1,1) for abc=000..111; out_valid=1.
- Four WIDTH=1, REG_OUT=0 slices rippled: a=4'hF, b=4'h1, cin=0 -> sum=4'h0, cout=1 same cycle; a=4'h5, b=4'h3, cin=1 -> sum=4'h9, cout=0.
- WIDTH=4, REG_OUT=1: a=4'b0111, b=4'b0001, cin=0 -> sum=4'b1000, cout=0, ovf=1, gen=0, prop=0; a=4'b1010, b=4'b0101, cin=1 -> sum=4'b0000, cout=1, gen=0, prop=1.
- Hold: a=1, b=1, cin=0 with in_valid=1, then in_valid=0 with a=0, b=0 -> sum=0, cout=1 retained; out_valid drops to 0.
- Reset: apply rst=1 for 1 cycle while in_valid=1 with a=1, b=1, cin=1 -> all outputs 0 next cycle; after release, in_valid=1 -> correct result one cycle later.
- Stimulus sweep: a increments every 4 steps, b every 2, cin toggles every step (4-slice ripple) -> {cout,sum} equals a+b+cin at every step.
